snitch_ssr_isect_master: RTL and testbench

Master-side endpoint of the SSR index intersection protocol. One instance sits in each indirect-stream SSR lane and faces one of the two master ports of the intersector. It holds the lane's current index and presents it, together with job flags, to the intersector. It applies the zero, skip and done responses, and turns every accepted handshake into a data-mover action: a fetch at `base + (idx << shift)`, or an injected zero element. It also drains leftover indices when the intersection ends early.

---
 rtl/snitch_ssr_isect_master.sv | 160 ++++++++++++++++
 tb/tb_snitch_ssr_isect_master.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_ssr_isect_master.sv
// Master-side endpoint of the SSR index intersection protocol.
// Holds one index, presents it to the intersector, queues data-mover actions.
module snitch_ssr_isect_master #(
   parameter int unsigned IdxWidth  = 16,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned ActDepth  = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [31:0]          cfg_len_i,
   input  logic [2:0]           cfg_shift_i,
   input  logic                 cfg_merge_i,
   input  logic                 cfg_slv_ena_i,
   input  logic                 idx_valid_i,
   output logic                 idx_ready_o,
   input  logic [IdxWidth-1:0]  idx_i,
   output logic [IdxWidth-1:0]  isect_idx_o,
   output logic                 isect_valid_o,
   output logic                 isect_done_o,
   output logic                 isect_merge_o,
   output logic                 isect_slv_ena_o,
   input  logic                 isect_zero_i,
   input  logic                 isect_skip_i,
   input  logic                 isect_done_i,
   input  logic                 isect_ready_i,
   output logic                 act_valid_o,
   input  logic                 act_ready_i,
   output logic [AddrWidth-1:0] act_addr_o,
   output logic                 act_zero_o,
   output logic                 busy_o
);

   localparam int unsigned PtrW = (ActDepth > 1) ? $clog2(ActDepth) : 1;
   localparam int unsigned CntW = $clog2(ActDepth + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e                state_q;
   logic [31:0]           rem_q, rem_d;
   logic                  hv_q;
   logic [IdxWidth-1:0]   hidx_q;
   logic [AddrWidth-1:0]  base_q;
   logic [2:0]            shift_q;
   logic                  merge_q, slv_ena_q;

   logic [AddrWidth:0]    mem_q [ActDepth];
   logic [PtrW-1:0]       wr_q, rd_q;
   logic [CntW-1:0]       cnt_q;

   logic run, drain, act_full;
   logic hs, hs_done, hs_zero, hs_skip, hs_fetch;
   logic pop_idx, load, push, act_pop;
   logic [AddrWidth-1:0]  fetch_addr;

   function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
      return (p == PtrW'(ActDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign run      = (state_q == RUN);
   assign drain    = (state_q == DRAIN);
   assign act_full = (cnt_q == CntW'(ActDepth));

   // Request side depends only on registered state, never on intersector inputs.
   assign isect_done_o  = run & ~hv_q & (rem_q == '0);
   assign isect_valid_o = run & (hv_q | isect_done_o) & ~act_full;
   assign isect_idx_o   = hv_q ? hidx_q : '1;
   assign isect_merge_o   = merge_q;
   assign isect_slv_ena_o = slv_ena_q;

   assign hs       = isect_valid_o & isect_ready_i;
   assign hs_done  = hs & isect_done_i;
   assign hs_zero  = hs & ~isect_done_i & isect_zero_i;
   assign hs_skip  = hs & ~isect_done_i & ~isect_zero_i & isect_skip_i;
   assign hs_fetch = hs & ~isect_done_i & ~isect_zero_i & ~isect_skip_i & hv_q;
   assign pop_idx  = hs_skip | hs_fetch;
   assign push     = hs_zero | hs_fetch;

   assign idx_ready_o = (rem_q != '0) & ((run & (~hv_q | pop_idx)) | drain);
   assign load        = idx_valid_i & idx_ready_o;
   assign rem_d       = load ? rem_q - 32'd1 : rem_q;

   assign fetch_addr = base_q + (AddrWidth'(hidx_q) << shift_q);

   assign cfg_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);

   assign act_valid_o = (cnt_q != '0);
   assign act_pop     = act_valid_o & act_ready_i;
   assign act_addr_o  = act_valid_o ? mem_q[rd_q][AddrWidth:1] : '0;
   assign act_zero_o  = act_valid_o & mem_q[rd_q][0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         hv_q      <= 1'b0;
         hidx_q    <= '0;
         base_q    <= '0;
         shift_q   <= '0;
         merge_q   <= 1'b0;
         slv_ena_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cfg_valid_i) begin
                  base_q    <= cfg_base_i;
                  shift_q   <= cfg_shift_i;
                  merge_q   <= cfg_merge_i;
                  slv_ena_q <= cfg_slv_ena_i;
                  rem_q     <= cfg_len_i;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               rem_q <= rem_d;
               if (hs_done) begin
                  hv_q    <= 1'b0;
                  state_q <= (rem_d == '0) ? IDLE : DRAIN;
               end else if (load) begin
                  hv_q   <= 1'b1;
                  hidx_q <= idx_i;
               end else if (pop_idx) begin
                  hv_q <= 1'b0;
               end
            end
            DRAIN: begin
               rem_q <= rem_d;
               if (rem_d == '0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(ActDepth); i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= {(hs_fetch ? fetch_addr : '0), hs_zero};
            wr_q        <= nxt(wr_q);
         end
         if (act_pop) rd_q <= nxt(rd_q);
         cnt_q <= cnt_q + CntW'(push) - CntW'(act_pop);
      end
   end

`ifndef SYNTHESIS
   a_zero_skip: assert property (@(posedge clk_i) disable iff (!rst_ni)
      hs |-> !(isect_zero_i && isect_skip_i))
      else $error("zero and skip asserted together");
`endif

endmodule

// File: tb/tb_snitch_ssr_isect_master.sv
// Directed bench for snitch_ssr_isect_master.
// Scripted intersector, index feeder and action collector.
module tb_snitch_ssr_isect_master;
   localparam int IW = 16;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          cfg_valid_i, cfg_ready_o;
   logic [AW-1:0] cfg_base_i;
   logic [31:0]   cfg_len_i;
   logic [2:0]    cfg_shift_i;
   logic          cfg_merge_i, cfg_slv_ena_i;
   logic          idx_valid_i, idx_ready_o;
   logic [IW-1:0] idx_i, isect_idx_o;
   logic          isect_valid_o, isect_done_o;
   logic          isect_merge_o, isect_slv_ena_o;
   logic          isect_zero_i, isect_skip_i;
   logic          isect_done_i, isect_ready_i;
   logic          act_valid_o, act_ready_i;
   logic [AW-1:0] act_addr_o;
   logic          act_zero_o, busy_o;

   snitch_ssr_isect_master #(
      .IdxWidth(IW), .AddrWidth(AW), .ActDepth(2)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i),
      .cfg_shift_i(cfg_shift_i), .cfg_merge_i(cfg_merge_i),
      .cfg_slv_ena_i(cfg_slv_ena_i),
      .idx_valid_i(idx_valid_i), .idx_ready_o(idx_ready_o),
      .idx_i(idx_i), .isect_idx_o(isect_idx_o),
      .isect_valid_o(isect_valid_o), .isect_done_o(isect_done_o),
      .isect_merge_o(isect_merge_o),
      .isect_slv_ena_o(isect_slv_ena_o),
      .isect_zero_i(isect_zero_i), .isect_skip_i(isect_skip_i),
      .isect_done_i(isect_done_i), .isect_ready_i(isect_ready_i),
      .act_valid_o(act_valid_o), .act_ready_i(act_ready_i),
      .act_addr_o(act_addr_o), .act_zero_o(act_zero_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int          idx_q [$];
   logic [2:0]  rsp_q [$];   // {done, zero, skip}
   logic [32:0] got_q [$];   // {addr, zero}
   int          n_idx, n_hs, n_drain;
   bit          done_seen;
   logic        done_o_seen;
   logic        act_rdy;

   task automatic run_cycle();
      int       t;
      logic [2:0] r;
      @(negedge clk);
      cfg_valid_i = 1'b0;
      idx_valid_i = 1'b0;
      idx_i = '0;
      if (idx_q.size() != 0) begin
         idx_valid_i = 1'b1;
         idx_i = IW'(idx_q[0]);
      end
      isect_ready_i = 1'b0;
      {isect_done_i, isect_zero_i, isect_skip_i} = 3'b000;
      if (rsp_q.size() != 0) begin
         isect_ready_i = 1'b1;
         {isect_done_i, isect_zero_i, isect_skip_i} = rsp_q[0];
      end
      act_ready_i = act_rdy;
      #1;
      if (act_valid_o && act_ready_i)
         got_q.push_back({act_addr_o, act_zero_o});
      if (idx_valid_i && idx_ready_o) begin
         t = idx_q.pop_front();
         n_idx++;
         if (done_seen) n_drain++;
      end
      if (isect_valid_o && isect_ready_i) begin
         n_hs++;
         r = rsp_q.pop_front();
         if (r[2]) begin
            done_seen = 1'b1;
            done_o_seen = isect_done_o;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) run_cycle();
   endtask

   task automatic do_cfg(input logic [AW-1:0] base, input int len,
                         input int sh, input bit mg, input bit se);
      @(negedge clk);
      cfg_valid_i   = 1'b1;
      cfg_base_i    = base;
      cfg_len_i     = len;
      cfg_shift_i   = 3'(sh);
      cfg_merge_i   = mg;
      cfg_slv_ena_i = se;
      idx_valid_i   = 1'b0;
      isect_ready_i = 1'b0;
      act_ready_i   = act_rdy;
      n_idx = 0; n_hs = 0; n_drain = 0;
      done_seen = 1'b0; done_o_seen = 1'b0;
      got_q.delete();
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      cfg_valid_i = 0; cfg_base_i = 0; cfg_len_i = 0;
      cfg_shift_i = 0; cfg_merge_i = 0; cfg_slv_ena_i = 0;
      idx_valid_i = 0; idx_i = 0;
      isect_zero_i = 0; isect_skip_i = 0;
      isect_done_i = 0; isect_ready_i = 0;
      act_ready_i = 0; act_rdy = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if ({cfg_ready_o, idx_ready_o, isect_valid_o, isect_done_o,
           act_valid_o, busy_o, isect_merge_o, isect_slv_ena_o,
           act_zero_o} !== 9'b100000000) begin
         miscompares++;
         $display("FAIL reset_flags got %b exp 100000000",
            {cfg_ready_o, idx_ready_o, isect_valid_o, isect_done_o,
             act_valid_o, busy_o, isect_merge_o, isect_slv_ena_o,
             act_zero_o});
      end
      vectors++;
      if (act_addr_o !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_addr got %h exp 0", act_addr_o);
      end
      vectors++;
      if (isect_idx_o !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL reset_idx got %h exp ffff", isect_idx_o);
      end
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_plain();
      logic [32:0] exp [3];
      logic [32:0] g;
      exp[0] = {32'h1010, 1'b0};
      exp[1] = {32'h1028, 1'b0};
      exp[2] = {32'h1048, 1'b0};
      act_rdy = 1'b1;
      do_cfg(32'h1000, 3, 3, 0, 0);
      idx_q = '{2, 5, 9};
      rsp_q = '{3'b000, 3'b000, 3'b000, 3'b100};
      run_cycle();
      vectors++;
      if (busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL plain_busy got %b exp 1", busy_o);
      end
      run(20);
      vectors++;
      if (got_q.size() != 3) begin
         miscompares++;
         $display("FAIL plain_count got %0d exp 3", got_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         vectors++;
         if (g !== exp[i]) begin
            miscompares++;
            $display("FAIL plain_act%0d got %h exp %h", i, g, exp[i]);
         end
      end
      vectors++;
      if ({done_o_seen, busy_o, n_idx == 3} !== 3'b101) begin
         miscompares++;
         $display("FAIL plain_done got done_o=%b busy=%b idx=%0d exp 1 0 3",
            done_o_seen, busy_o, n_idx);
      end
   endtask

   task automatic test_skip_zero();
      logic [32:0] exp [2];
      logic [32:0] g;
      exp[0] = {32'h0, 1'b1};
      exp[1] = {32'h201C, 1'b0};
      do_cfg(32'h2000, 2, 2, 0, 0);
      idx_q = '{4, 7};
      rsp_q = '{3'b001, 3'b010, 3'b000, 3'b100};
      run(20);
      vectors++;
      if (got_q.size() != 2) begin
         miscompares++;
         $display("FAIL skipzero_count got %0d exp 2", got_q.size());
      end
      for (int i = 0; i < 2; i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         vectors++;
         if (g !== exp[i]) begin
            miscompares++;
            $display("FAIL skipzero_act%0d got %h exp %h", i, g, exp[i]);
         end
      end
      vectors++;
      if ({done_o_seen, busy_o, n_idx == 2} !== 3'b101) begin
         miscompares++;
         $display("FAIL skipzero_end got done_o=%b busy=%b idx=%0d exp 1 0 2",
            done_o_seen, busy_o, n_idx);
      end
   endtask

   task automatic test_drain();
      do_cfg(32'h0, 5, 0, 0, 0);
      idx_q = '{10, 11, 12, 13, 14};
      rsp_q = '{3'b000, 3'b100};
      run(4);
      vectors++;
      if ({busy_o, isect_valid_o, idx_ready_o} !== 3'b101) begin
         miscompares++;
         $display("FAIL drain_state got busy/valid/ready %b exp 101",
            {busy_o, isect_valid_o, idx_ready_o});
      end
      run(16);
      vectors++;
      if (n_drain != 3) begin
         miscompares++;
         $display("FAIL drain_beats got %0d exp 3", n_drain);
      end
      vectors++;
      if (busy_o !== 1'b0 || got_q.size() != 1) begin
         miscompares++;
         $display("FAIL drain_end got busy=%b acts=%0d exp 0 1",
            busy_o, got_q.size());
      end
      vectors++;
      if (got_q.size() != 0 && got_q[0] !== {32'd10, 1'b0}) begin
         miscompares++;
         $display("FAIL drain_act got %h exp %h", got_q[0], {32'd10, 1'b0});
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] g;
      logic [AW-1:0] ea;
      act_rdy = 1'b0;
      do_cfg(32'h100, 4, 1, 0, 0);
      idx_q = '{1, 2, 3, 4};
      rsp_q = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
      run(10);
      vectors++;
      if (n_hs != 2 || isect_valid_o !== 1'b0 || act_valid_o !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_stall got hs=%0d valid=%b act=%b exp 2 0 1",
            n_hs, isect_valid_o, act_valid_o);
      end
      act_rdy = 1'b1;
      run(20);
      vectors++;
      if (got_q.size() != 4 || n_hs != 5 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_resume got acts=%0d hs=%0d busy=%b exp 4 5 0",
            got_q.size(), n_hs, busy_o);
      end
      for (int i = 0; i < 4; i++) begin
         ea = 32'h100 + 32'(2 * (i + 1));
         g = (i < got_q.size()) ? got_q[i] : 'x;
         vectors++;
         if (g !== {ea, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_act%0d got %h exp %h", i, g, {ea, 1'b0});
         end
      end
   endtask

   task automatic test_boundaries();
      act_rdy = 1'b1;
      do_cfg(32'h0, 0, 0, 0, 0);
      run_cycle();
      vectors++;
      if ({isect_done_o, isect_valid_o, idx_ready_o} !== 3'b110) begin
         miscompares++;
         $display("FAIL len0 got done/valid/ready %b exp 110",
            {isect_done_o, isect_valid_o, idx_ready_o});
      end
      rsp_q = '{3'b100};
      run(4);
      vectors++;
      if (busy_o !== 1'b0 || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL len0_end got busy=%b acts=%0d exp 0 0",
            busy_o, got_q.size());
      end
      do_cfg(32'hFFFF_FFF8, 1, 3, 0, 0);
      idx_q = '{1};
      rsp_q = '{3'b000, 3'b100};
      run(10);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== {32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL wrap got n=%0d act=%h exp 1 %h",
            got_q.size(), (got_q.size() != 0) ? got_q[0] : 33'h0,
            {32'h0, 1'b0});
      end
   endtask

   task automatic test_merge_done();
      do_cfg(32'h4000, 0, 2, 1, 1);
      run_cycle();
      vectors++;
      if ({isect_merge_o, isect_slv_ena_o, isect_done_o} !== 3'b111) begin
         miscompares++;
         $display("FAIL merge_flags got %b exp 111",
            {isect_merge_o, isect_slv_ena_o, isect_done_o});
      end
      rsp_q = '{3'b010, 3'b010, 3'b100};
      run(10);
      vectors++;
      if (got_q.size() != 2 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL merge_count got acts=%0d busy=%b exp 2 0",
            got_q.size(), busy_o);
      end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (i < got_q.size() && got_q[i] !== {32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL merge_act%0d got %h exp %h",
               i, got_q[i], {32'h0, 1'b1});
         end
      end
   endtask

   task automatic test_reset_mid_run();
      act_rdy = 1'b0;
      do_cfg(32'h800, 4, 0, 1, 1);
      idx_q = '{1, 2, 3, 4};
      rsp_q = '{3'b000, 3'b000};
      run(8);
      vectors++;
      if ({act_valid_o, isect_merge_o, busy_o} !== 3'b111) begin
         miscompares++;
         $display("FAIL midrst_pre got %b exp 111",
            {act_valid_o, isect_merge_o, busy_o});
      end
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      vectors++;
      if ({cfg_ready_o, idx_ready_o, isect_valid_o, isect_done_o,
           act_valid_o, busy_o, isect_merge_o, isect_slv_ena_o,
           act_zero_o} !== 9'b100000000) begin
         miscompares++;
         $display("FAIL midrst_flags got %b exp 100000000",
            {cfg_ready_o, idx_ready_o, isect_valid_o, isect_done_o,
             act_valid_o, busy_o, isect_merge_o, isect_slv_ena_o,
             act_zero_o});
      end
      vectors++;
      if (act_addr_o !== 32'h0 || isect_idx_o !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL midrst_data got addr=%h idx=%h exp 0 ffff",
            act_addr_o, isect_idx_o);
      end
      idx_q.delete();
      rsp_q.delete();
      @(negedge clk);
      rst_ni = 1'b1;
      act_rdy = 1'b1;
      do_cfg(32'h0, 0, 0, 0, 0);
      vectors++;
      if (cfg_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_cfg got %b exp 1", cfg_ready_o);
      end
      run_cycle();
      vectors++;
      if ({busy_o, isect_done_o} !== 2'b11) begin
         miscompares++;
         $display("FAIL midrst_run got %b exp 11", {busy_o, isect_done_o});
      end
      rsp_q = '{3'b100};
      run(4);
      vectors++;
      if (busy_o !== 1'b0 || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL midrst_flush got busy=%b acts=%0d exp 0 0",
            busy_o, got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_plain();
      test_skip_zero();
      test_drain();
      test_backpressure();
      test_boundaries();
      test_merge_done();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==",
         vectors, miscompares);
      $finish;
   end

endmodule
